// File: rtl/pcie_sym_pkg.sv
// Shared PCIe symbol definitions: K-symbol bytes, 4-bit symbol codes and the
// receive framing state enum. Also used by the transmit symbol multiplexer.
package pcie_sym_pkg;

  localparam int MAX_LEN_DEF = 64;
  localparam int MAX_SKP_DEF = 5;

  localparam logic [7:0] SYM_COM = 8'hBC;
  localparam logic [7:0] SYM_PAD = 8'hF7;
  localparam logic [7:0] SYM_SKP = 8'h1C;
  localparam logic [7:0] SYM_STP = 8'hFB;
  localparam logic [7:0] SYM_SDP = 8'h5C;
  localparam logic [7:0] SYM_END = 8'hFD;
  localparam logic [7:0] SYM_EDB = 8'hFE;
  localparam logic [7:0] SYM_FTS = 8'h3C;
  localparam logic [7:0] SYM_IDL = 8'h7C;

  localparam logic [3:0] CODE_DATA = 4'b0000;
  localparam logic [3:0] CODE_COM  = 4'b0001;
  localparam logic [3:0] CODE_PAD  = 4'b0010;
  localparam logic [3:0] CODE_SKP  = 4'b0011;
  localparam logic [3:0] CODE_STP  = 4'b0100;
  localparam logic [3:0] CODE_SDP  = 4'b0101;
  localparam logic [3:0] CODE_END  = 4'b0110;
  localparam logic [3:0] CODE_EDB  = 4'b0111;
  localparam logic [3:0] CODE_FTS  = 4'b1000;
  localparam logic [3:0] CODE_IDL  = 4'b1001;
  localparam logic [3:0] CODE_UNK  = 4'b1111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PKT  = 2'd1,
    ST_OS   = 2'd2
  } state_t;

  // Registered output bundle of the receive demultiplexer.
  typedef struct packed {
    logic [7:0] data;
    logic [3:0] ctrl;
    logic       vld;
    logic       tlp_vld;
    logic       tlp_sop;
    logic       tlp_eop;
    logic       tlp_drop;
    logic       pkt_dllp;
    logic       os_skp;
    logic [2:0] skp_cnt;
    logic       frm_err;
  } demux_out_t;

  function automatic logic is_open(input logic [3:0] code);
    return (code == CODE_STP) || (code == CODE_SDP);
  endfunction

endpackage

// File: rtl/demultiplexer_cond_if.sv
// Receive symbol stream in, classified symbols and framing pulses out.
interface demultiplexer_cond_if;
  // Valid-only stream, no backpressure: demuxIN/demuxK are consumed on every
  // clock where demuxINVLD=1; every output is a one-cycle pulse one clock later.
  logic [7:0] demuxIN;
  logic       demuxK;
  logic       demuxINVLD;
  logic [7:0] demuxOUT;
  logic [3:0] demuxCTRL;
  logic       demuxVLD;
  logic       tlpVLD;
  logic       tlpSOP;
  logic       tlpEOP;
  logic       tlpDROP;
  logic       pktDLLP;
  logic       osSKP;
  logic [2:0] skpCNT;
  logic       frmERR;

  modport master (
    output demuxIN, demuxK, demuxINVLD,
    input  demuxOUT, demuxCTRL, demuxVLD, tlpVLD, tlpSOP, tlpEOP, tlpDROP,
           pktDLLP, osSKP, skpCNT, frmERR
  );

  modport slave (
    input  demuxIN, demuxK, demuxINVLD,
    output demuxOUT, demuxCTRL, demuxVLD, tlpVLD, tlpSOP, tlpEOP, tlpDROP,
           pktDLLP, osSKP, skpCNT, frmERR
  );
endinterface

// File: rtl/demux_sym_decode.sv
// Combinational symbol classifier: received byte plus K flag to 4-bit code.
module demux_sym_decode
  import pcie_sym_pkg::*;
(
  input  logic [7:0] sym,
  input  logic       is_k,
  output logic [3:0] code,
  output logic       known
);

  always_comb begin
    code  = CODE_DATA;
    known = 1'b1;
    if (is_k) begin
      unique case (sym)
        SYM_COM: code = CODE_COM;
        SYM_PAD: code = CODE_PAD;
        SYM_SKP: code = CODE_SKP;
        SYM_STP: code = CODE_STP;
        SYM_SDP: code = CODE_SDP;
        SYM_END: code = CODE_END;
        SYM_EDB: code = CODE_EDB;
        SYM_FTS: code = CODE_FTS;
        SYM_IDL: code = CODE_IDL;
        default: begin
          code  = CODE_UNK;
          known = 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/demultiplexer_cond.sv
// Receive symbol demultiplexer: classifies decoded bytes and recovers packet
// (STP/SDP..END/EDB) and SKP ordered-set framing.
module demultiplexer_cond
  import pcie_sym_pkg::*;
#(
  parameter int MAX_LEN = MAX_LEN_DEF,
  parameter int MAX_SKP = MAX_SKP_DEF
) (
  input  logic                 demuxCLK,
  input  logic                 demuxRST,
  demultiplexer_cond_if.slave  bus,
  output state_t               fsm_state
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);
  localparam logic [2:0]    SKP_MAX = 3'(MAX_SKP);

  state_t        state_q, state_d;
  logic [LW-1:0] len_q, len_d;
  logic [2:0]    skp_q, skp_d;
  logic          dllp_q, dllp_d;
  demux_out_t    out_q, out_d;

  logic [3:0] code;
  logic       known;
  logic       idle_like;

  demux_sym_decode u_decode (
    .sym   (bus.demuxIN),
    .is_k  (bus.demuxK),
    .code  (code),
    .known (known)
  );

  // A non-SKP symbol ends an ordered set and is then handled as from IDLE.
  assign idle_like = (state_q == ST_IDLE) ||
                     ((state_q == ST_OS) && (code != CODE_SKP));

  always_ff @(posedge demuxCLK) begin
    if (demuxRST) begin
      state_q <= ST_IDLE;
      len_q   <= '0;
      skp_q   <= '0;
      dllp_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      skp_q   <= skp_d;
      dllp_q  <= dllp_d;
      out_q   <= out_d;
    end
  end

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    skp_d   = skp_q;
    dllp_d  = dllp_q;
    if (bus.demuxINVLD) begin
      if (idle_like) begin
        state_d = ST_IDLE;
        if (is_open(code)) begin
          state_d = ST_PKT;
          len_d   = '0;
          dllp_d  = (code == CODE_SDP);
        end else if (code == CODE_COM) begin
          state_d = ST_OS;
          skp_d   = '0;
        end
      end else if (state_q == ST_OS) begin
        if (skp_q != 3'd7) skp_d = skp_q + 3'd1;
      end else begin
        unique case (code)
          CODE_DATA: begin
            if (len_q < LEN_MAX) len_d = len_q + 1'b1;
            else                 state_d = ST_IDLE;
          end
          CODE_STP, CODE_SDP: begin
            len_d  = '0;
            dllp_d = (code == CODE_SDP);
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    out_d = '0;
    if (bus.demuxINVLD) begin
      out_d.data    = bus.demuxIN;
      out_d.ctrl    = code;
      out_d.vld     = known;
      out_d.frm_err = ~known;
      if (idle_like) begin
        if ((state_q == ST_OS) && (skp_q != 3'd0)) begin
          out_d.os_skp  = 1'b1;
          out_d.skp_cnt = skp_q;
        end
        if ((code == CODE_END) || (code == CODE_EDB)) out_d.frm_err = 1'b1;
      end else if (state_q == ST_OS) begin
        if (skp_q >= SKP_MAX) out_d.frm_err = 1'b1;
      end else begin
        unique case (code)
          CODE_DATA: begin
            if (len_q < LEN_MAX) begin
              out_d.tlp_vld  = 1'b1;
              out_d.tlp_sop  = (len_q == '0);
              out_d.pkt_dllp = dllp_q;
            end else begin
              out_d.frm_err  = 1'b1;
              out_d.tlp_drop = 1'b1;
            end
          end
          CODE_END: begin
            if (len_q != '0) begin
              out_d.tlp_eop  = 1'b1;
              out_d.pkt_dllp = dllp_q;
            end else begin
              out_d.frm_err  = 1'b1;
              out_d.tlp_drop = 1'b1;
            end
          end
          CODE_EDB: out_d.tlp_drop = 1'b1;
          default: begin
            out_d.frm_err  = 1'b1;
            out_d.tlp_drop = 1'b1;
          end
        endcase
      end
    end
  end

  assign bus.demuxOUT  = out_q.data;
  assign bus.demuxCTRL = out_q.ctrl;
  assign bus.demuxVLD  = out_q.vld;
  assign bus.tlpVLD    = out_q.tlp_vld;
  assign bus.tlpSOP    = out_q.tlp_sop;
  assign bus.tlpEOP    = out_q.tlp_eop;
  assign bus.tlpDROP   = out_q.tlp_drop;
  assign bus.pktDLLP   = out_q.pkt_dllp;
  assign bus.osSKP     = out_q.os_skp;
  assign bus.skpCNT    = out_q.skp_cnt;
  assign bus.frmERR    = out_q.frm_err;
  assign fsm_state     = state_q;

endmodule
